// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, constants and bus FSM encoding for the fetch stage
// Purpose: common definitions imported by if_bus_master and if_stage.
package if_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  localparam word_data_t ISA_NOP              = 32'h0000_0000;
  localparam word_addr_t RESET_VECTOR_DEFAULT = 30'h0;

  // Active-high and active-low assertion levels.
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2
  } bus_if_state_e;

endpackage

// File: rtl/if_bus_master.sv
// rtl/if_bus_master.sv - instruction-bus master FSM (IDLE -> REQ -> ACCESS) with squash
// Purpose: runs one read access per req_i, reports the returned word with done_o and
//          silently drops a completion whose fetch was killed while in flight.
// Ports:
//   clk, reset_      clock, asynchronous active-low reset
//   req_i            start a fetch when idle
//   addr_i           word address, sampled when the address strobe is issued
//   kill_i           redirect seen; an access in flight will be discarded
//   done_o           fetched word valid this cycle (rd_data_o)
//   in_flight_o      FSM is not idle
//   bus_*            active-low request/grant/strobe/ready bus handshake
module if_bus_master
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   req_i,
  input  logic [WORD_ADDR_W-1:0] addr_i,
  input  logic                   kill_i,
  output logic                   done_o,
  output logic [WORD_DATA_W-1:0] rd_data_o,
  output logic                   in_flight_o,
  output logic                   bus_req_o,
  input  logic                   bus_grnt_i,
  output logic                   bus_as_o,
  output logic [WORD_ADDR_W-1:0] bus_addr_o,
  input  logic [WORD_DATA_W-1:0] bus_rd_data_i,
  input  logic                   bus_rdy_i
);

  bus_if_state_e state_q, state_d;
  logic          req_q, req_d;
  logic          as_q, as_d;
  logic          squash_q, squash_d;
  word_addr_t    addr_q, addr_d;
  logic          rdy_seen;

  assign rdy_seen = (state_q == BUS_IF_STATE_ACCESS) && (bus_rdy_i == ENABLE_);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    as_d     = DISABLE_;
    addr_d   = addr_q;
    squash_d = squash_q;
    case (state_q)
      BUS_IF_STATE_IDLE: begin
        if (req_i) begin
          req_d   = ENABLE_;
          state_d = BUS_IF_STATE_REQ;
        end
      end
      BUS_IF_STATE_REQ: begin
        if (bus_grnt_i == ENABLE_) begin
          as_d    = ENABLE_;
          addr_d  = addr_i;
          state_d = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        if (rdy_seen) begin
          req_d   = DISABLE_;
          state_d = BUS_IF_STATE_IDLE;
        end
      end
      default: begin
        req_d   = DISABLE_;
        state_d = BUS_IF_STATE_IDLE;
      end
    endcase
    // A redirect on the completing cycle needs no squash: the top drops that word itself.
    if (rdy_seen) begin
      squash_d = 1'b0;
    end else if (kill_i && (state_q != BUS_IF_STATE_IDLE)) begin
      squash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= BUS_IF_STATE_IDLE;
      req_q    <= DISABLE_;
      as_q     <= DISABLE_;
      addr_q   <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      as_q     <= as_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
    end
  end

  assign done_o      = rdy_seen && !squash_q;
  assign rd_data_o   = bus_rd_data_i;
  assign in_flight_o = (state_q != BUS_IF_STATE_IDLE);
  assign bus_req_o   = req_q;
  assign bus_as_o    = as_q;
  assign bus_addr_o  = addr_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, one-entry holding buffer, IF/ID register
// Purpose: fetches sequential words through if_bus_master and presents them to decode,
//          honouring flush > stall > branch > data priority each cycle.
// Optional feature: define IF_PERF_CNT_EN to build the saturating fetch_wait_cnt counter
//          (cycles with busy high and no valid instruction); otherwise it is tied to 0.
// Ports:
//   clk, reset_            clock, asynchronous active-low reset
//   stall, flush, new_pc   pipeline-controller hold / redirect
//   br_taken, br_addr      branch redirect from decode
//   bus_*                  instruction-memory bus (active-low handshake, bus_rw = read)
//   busy                   fetch outstanding
//   if_pc, if_insn, if_en  IF/ID pipeline register
//   fetch_wait_cnt         performance counter
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int         PERF_CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic                   busy,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en,
  output logic [PERF_CNT_W-1:0]  fetch_wait_cnt
);

  word_addr_t pc_q, pc_d;
  word_addr_t if_pc_q, if_pc_d;
  word_data_t if_insn_q, if_insn_d;
  logic       if_en_q, if_en_d;
  word_data_t buf_q, buf_d;
  logic       buf_valid_q, buf_valid_d;

  logic       done;
  logic       in_flight;
  logic       kill;
  word_data_t rd_data;

  // A branch seen under stall is ignored, so it must not squash the access either.
  assign kill = flush || (br_taken && !stall);

  if_bus_master u_bus_master (
    .clk           (clk),
    .reset_        (reset_),
    .req_i         (!buf_valid_q),
    .addr_i        (pc_q),
    .kill_i        (kill),
    .done_o        (done),
    .rd_data_o     (rd_data),
    .in_flight_o   (in_flight),
    .bus_req_o     (bus_req_),
    .bus_grnt_i    (bus_grnt_),
    .bus_as_o      (bus_as_),
    .bus_addr_o    (bus_addr),
    .bus_rd_data_i (bus_rd_data),
    .bus_rdy_i     (bus_rdy_)
  );

  always_comb begin
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_insn_d   = if_insn_q;
    if_en_d     = if_en_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (flush) begin
      if_insn_d   = ISA_NOP;
      if_en_d     = DISABLE;
      pc_d        = new_pc;
      buf_valid_d = 1'b0;
    end else if (stall) begin
      // Park the word; pc only advances once it reaches IF/ID.
      if (done) begin
        buf_d       = rd_data;
        buf_valid_d = 1'b1;
      end
    end else if (br_taken) begin
      if_insn_d   = ISA_NOP;
      if_en_d     = DISABLE;
      pc_d        = br_addr;
      buf_valid_d = 1'b0;
    end else if (done || buf_valid_q) begin
      if_pc_d     = pc_q;
      if_insn_d   = buf_valid_q ? buf_q : rd_data;
      if_en_d     = ENABLE;
      pc_d        = pc_q + WORD_ADDR_W'(1);
      buf_valid_d = 1'b0;
    end else begin
      if_insn_d = ISA_NOP;
      if_en_d   = DISABLE;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pc_q        <= RESET_VECTOR;
      if_pc_q     <= RESET_VECTOR;
      if_insn_q   <= ISA_NOP;
      if_en_q     <= DISABLE;
      buf_q       <= ISA_NOP;
      buf_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_insn_q   <= if_insn_d;
      if_en_q     <= if_en_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Idle with an empty buffer always starts a fetch, so it already counts as busy.
  assign busy    = reset_ && (in_flight || !buf_valid_q);
  assign bus_rw  = 1'b1;
  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;

`ifdef IF_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wait_cnt_q <= '0;
    end else if (busy && !if_en_q && !(&wait_cnt_q)) begin
      wait_cnt_q <= wait_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign fetch_wait_cnt = wait_cnt_q;
`else
  assign fetch_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: directed scenarios then random redirects/stalls
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_, stall, flush, br_taken, bus_grnt_, bus_rdy_;
  logic [29:0] new_pc, br_addr;
  logic        bus_req_, bus_as_, bus_rw, busy, if_en;
  logic [29:0] bus_addr, if_pc;
  logic [31:0] bus_rd_data, if_insn, fetch_wait_cnt;

  if_stage #(.RESET_VECTOR(30'h0), .PERF_CNT_W(32)) dut (
    .clk            (clk),
    .reset_         (reset_),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_taken       (br_taken),
    .br_addr        (br_addr),
    .bus_req_       (bus_req_),
    .bus_grnt_      (bus_grnt_),
    .bus_as_        (bus_as_),
    .bus_rw         (bus_rw),
    .bus_addr       (bus_addr),
    .bus_rd_data    (bus_rd_data),
    .bus_rdy_       (bus_rdy_),
    .busy           (busy),
    .if_pc          (if_pc),
    .if_insn        (if_insn),
    .if_en          (if_en),
    .fetch_wait_cnt (fetch_wait_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  bit          mon_en = 1'b0;
  bit          grnt_random = 1'b0;
  bit          fixed_delays = 1'b1;
  int          rdy_max = 0;
  logic [29:0] exp_q[$];
  logic [29:0] next_push;
  logic [29:0] exp_pc;

  // Reference: memory word i holds A000_0000 + i; after any redirect the delivered
  // stream is target, target+1, ... (30-bit wrap).
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hA000_0000 + {2'b00, a};
  endfunction

  function automatic void top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back(next_push);
      next_push = next_push + 30'd1;
    end
  endfunction

  function automatic void restart(input logic [29:0] target);
    exp_q.delete();
    next_push = target;
    top_up();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: grant and ready, with per-address or random wait states.
  bit pend;
  int rdy_cnt;
  initial begin
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0; pend = 1'b0; rdy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset_ !== 1'b1) begin
        pend = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
      end else begin
        bus_grnt_ = (bus_req_ == 1'b0 && (!grnt_random || $urandom_range(0, 2) == 0)) ? 1'b0 : 1'b1;
        if (bus_as_ == 1'b0) begin
          pend = 1'b1;
          bus_rd_data = mem_word(bus_addr);
          if (fixed_delays && bus_addr == 30'd5)      rdy_cnt = 4;
          else if (fixed_delays && bus_addr == 30'd9) rdy_cnt = 2;
          else                                        rdy_cnt = int'($urandom_range(0, rdy_max));
        end
        bus_rdy_ = 1'b1;
        if (pend) begin
          if (rdy_cnt == 0) begin
            bus_rdy_ = 1'b0;
            pend = 1'b0;
          end else begin
            rdy_cnt--;
          end
        end
      end
    end
  end

  // Monitor: every fresh IF/ID load (if_en high, not held by stall) pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_ === 1'b1 && if_en === 1'b1 && stall === 1'b0) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver_unexpected actual_pc=%0h required=none", if_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          top_up();
          chk("deliver_pc", 64'(if_pc), 64'(exp_pc));
          chk("deliver_insn", 64'(if_insn), 64'(mem_word(exp_pc)));
        end
      end
    end
  end

  initial begin
    logic [31:0] c12, c15, c22;
    int d0;
    c12 = 0; c15 = 0; c22 = 0;
    reset_ = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; new_pc = '0; br_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus_req", 64'(bus_req_), 64'(1));
    chk("rst_bus_as", 64'(bus_as_), 64'(1));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_rw", 64'(bus_rw), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_if_pc", 64'(if_pc), 64'(0));
    chk("rst_if_insn", 64'(if_insn), 64'(0));
    chk("rst_if_en", 64'(if_en), 64'(0));
    chk("rst_wait_cnt", 64'(fetch_wait_cnt), 64'(0));

    restart(30'h0);
    reset_ = 1'b1;
    mon_en = 1'b1;

    // k counts posedges since reset release; expected if_en pattern follows the
    // 3-cycle fetch, the 4-cycle rdy delay on pc 5, the stall on pc 8 and the redirects.
    for (int k = 1; k <= 49; k++) begin
      tick();
      chk($sformatf("dir_if_en_k%0d", k), 64'(if_en),
          64'(k inside {3, 6, 9, 12, 15, 22, 25, 28, 35, 43, 49}));
      if (k == 3)  chk("first_pc", 64'(if_pc), 64'(0));
      if (k == 12) c12 = fetch_wait_cnt;
      if (k == 15) c15 = fetch_wait_cnt;
      if (k == 22) c22 = fetch_wait_cnt;
      if (k >= 16 && k <= 21) chk($sformatf("delay_busy_k%0d", k), 64'(busy), 64'(1));
      if (k == 22) chk("delay_pc5", 64'(if_pc), 64'(5));
      if (k >= 31 && k <= 34) begin
        chk($sformatf("stall_no_req_k%0d", k), 64'(bus_req_), 64'(1));
        chk($sformatf("stall_buf_idle_k%0d", k), 64'(busy), 64'(0));
        chk($sformatf("stall_hold_pc_k%0d", k), 64'(if_pc), 64'(7));
      end
      if (k == 35) chk("stall_release_pc8", 64'(if_pc), 64'(8));
      if (k == 43) chk("branch_target_pc", 64'(if_pc), 64'(30'h40));
      if (k == 49) chk("flush_target_pc", 64'(if_pc), 64'(30'h100));
      // stimulus for the next edge
      if (k == 29) stall = 1'b1;
      if (k == 34) stall = 1'b0;
      if (k == 37) begin br_taken = 1'b1; br_addr = 30'h40; restart(30'h40); end
      if (k == 38) br_taken = 1'b0;
      if (k == 44) begin
        flush = 1'b1; new_pc = 30'h100; br_taken = 1'b1; br_addr = 30'h40; restart(30'h100);
      end
      if (k == 45) begin flush = 1'b0; br_taken = 1'b0; end
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_delay_plus4", 64'(c22 - c15), 64'((c15 - c12) + 32'd4));
`else
    chk("perf_tied_zero", 64'(c12 | c15 | c22), 64'(0));
`endif

    // Edge 50 moves IDLE -> REQ; reset in the middle of that request.
    tick();
    chk("pre_reset_in_req", 64'(bus_req_), 64'(0));
    reset_ = 1'b0;
    #1;
    chk("async_rst_bus_req", 64'(bus_req_), 64'(1));
    chk("async_rst_bus_as", 64'(bus_as_), 64'(1));
    chk("async_rst_busy", 64'(busy), 64'(0));
    tick();
    restart(30'h0);
    reset_ = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("restart_if_en_k%0d", k), 64'(if_en), 64'(k == 3));
    end
    chk("restart_pc", 64'(if_pc), 64'(0));

    // Random phase: bus wait states, stalls, branches, flushes (with 30-bit wrap targets).
    grnt_random = 1'b1; rdy_max = 3; fixed_delays = 1'b0;
    d0 = delivered;
    for (int n = 0; n < 2500; n++) begin
      tick();
      stall    = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      br_taken = ($urandom_range(0, 29) == 0);
      new_pc   = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      br_addr  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFD : 30'($urandom);
      if (flush)                    restart(new_pc);
      else if (br_taken && !stall)  restart(br_addr);
    end
    tick();
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    repeat (20) tick();
    chk("random_progress", 64'((delivered - d0) >= 100), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the AZ pipeline. It owns the PC and runs a bus-master handshake to instruction memory.
- Drives the IF/ID pipeline register (if_pc, if_insn, if_en) consumed by the instruction decoder.
- Reacts to branch redirects from ID, and to stall and flush from the pipeline controller.

Parameters:
- RESET_VECTOR, 30'h0, word address fetched first after reset.
- PERF_CNT_W, 32, width of the optional fetch-wait counter.

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- stall  in  1  hold the IF/ID register and the PC
- flush  in  1  discard the current fetch and redirect to new_pc
- new_pc  in  30  exception or exception-return target word address
- br_taken  in  1  branch taken, from decoder
- br_addr  in  30  branch target word address, from decoder
- bus_req_  out  1  bus request, active low
- bus_grnt_  in  1  bus grant, active low
- bus_as_  out  1  address strobe, active low, one cycle
- bus_rw  out  1  constant 1 (read)
- bus_addr  out  30  fetch word address
- bus_rd_data  in  32  fetched instruction
- bus_rdy_  in  1  data ready, active low
- busy  out  1  fetch outstanding; the pipeline controller stalls on it
- if_pc  out  30  word address of if_insn
- if_insn  out  32  instruction to decoder
- if_en  out  1  if_insn valid
- fetch_wait_cnt  out  PERF_CNT_W  optional performance counter

Behaviour:
- Reset (async, reset_ low) values:
  - pc = RESET_VECTOR
  - if_pc = RESET_VECTOR, if_insn = ISA_NOP (32'h0), if_en = 0
  - bus_req_ = 1, bus_as_ = 1, bus_addr = 0
  - busy = 0, FSM = IDLE, buf_valid = 0, squash = 0, fetch_wait_cnt = 0
  - Reset mid-access abandons the access; no bus signal stays asserted.
- FSM states IDLE -> REQ -> ACCESS -> IDLE:
  - IDLE: if buf_valid = 0, drive bus_req_ = 0 and go to REQ.
  - REQ: hold bus_req_ = 0. When bus_grnt_ = 0, drive bus_as_ = 0 and bus_addr = pc for exactly one cycle, then go to ACCESS.
  - ACCESS: hold bus_req_ = 0 and wait for bus_rdy_ = 0. On the cycle it is seen, capture bus_rd_data, release bus_req_ = 1, return to IDLE.
  - Minimum latency: 3 cycles from IDLE to data captured, with zero-wait grant and ready.
- busy = 1 whenever state != IDLE, or when in IDLE with buf_valid = 0 and a fetch about to start.
- Holding buffer (one entry):
  - Data captured while stall = 1 goes to insn_buf and sets buf_valid.
  - No new fetch is issued while buf_valid = 1.
  - The buffer drains into IF/ID on the first cycle with stall = 0.
- IF/ID register update priority, evaluated each posedge:
  1. flush: if_insn = NOP, if_en = 0, pc = new_pc, buf_valid = 0. If state != IDLE, set squash.
  2. stall: hold if_pc, if_insn, if_en and pc.
  3. br_taken: if_insn = NOP, if_en = 0, pc = br_addr, buf_valid = 0. Set squash if an access is in flight.
  4. Data available (captured this cycle or buffered): if_pc = pc, if_insn = data, if_en = 1, pc = pc + 1 (wraps modulo 2^30).
  5. Otherwise, bubble: if_insn = NOP, if_en = 0, if_pc held.
- Squash rules:
  - Completion of a squashed access is dropped and squash clears.
  - The next fetch uses the redirected pc.
  - Flush and br_taken arriving together: flush wins.
- No delay slot. The instruction following a taken branch is never delivered.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: fetch_wait_cnt increments each cycle with busy = 1 and if_en output 0, saturating at all ones; reset to 0.
- Undefined: fetch_wait_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared headers (cpu.h, isa.h, bus.h):
  - ISA_NOP
  - WordAddrBus / WordDataBus widths
  - BUS_IF_STATE_IDLE / REQ / ACCESS encodings
  - ENABLE / ENABLE_ / DISABLE_ constants
  - RESET_VECTOR default
- Sub-module if_bus_master: the FSM plus capture logic. It exposes a req/addr/rd_data/done/squash interface to the if_stage top, which holds the PC, the buffer and the IF/ID register.

Test Plan:
- Reset release, grant and ready zero-wait, memory word i = 32'hA000_0000 + i:
  - First if_en = 1 at cycle 3 with if_pc = 0, if_insn = 32'hA000_0000.
  - Then one instruction every 3 cycles, pc incrementing.
- bus_rdy_ delayed 4 cycles on the fetch of pc = 5:
  - busy = 1 throughout, if_en = 0 bubbles.
  - Then if_pc = 5 delivered.
  - fetch_wait_cnt increments by 4 when IF_PERF_CNT_EN is defined.
- stall held 5 cycles while the fetch of pc = 8 completes:
  - IF/ID holds the old values and buf_valid = 1 with no new bus_req_.
  - On stall release, if_pc = 8 is delivered next cycle.
- br_taken with br_addr = 30'h40 during ACCESS for pc = 9:
  - The returning data for pc = 9 is dropped.
  - Next delivered if_pc = 30'h40, and pc = 9 never has if_en = 1.
- flush with new_pc = 30'h100, same cycle as br_taken with br_addr = 30'h40:
  - Next delivered if_pc = 30'h100, if_en = 0 in between.
- reset_ asserted in the middle of REQ:
  - bus_req_ = 1 and bus_as_ = 1 immediately (async).
  - After release, fetch restarts at RESET_VECTOR.
